// File: rtl/ball_physics.sv
`default_nettype none
// ============================================================================
// Module  : ball_physics
// Purpose : Per-frame ball motion engine (bounce, gravity, floor damping, kick)
// Rev     : 1.0  initial release
// ============================================================================
module ball_physics #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int RADIUS   = 20,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240,
  parameter int GRAVITY  = 1,
  parameter int MAX_VY   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic       kick,
  input  logic [1:0] speed_sel,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [5:0] vy_out,
  output logic       busy,
  output logic       bounce_x,
  output logic       bounce_y,
  output logic       missed_tick,
  output logic [7:0] frame_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC_X = 2'd1;
  localparam logic [1:0] ST_CALC_Y = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  localparam logic [10:0]        C_XMIN  = 11'(RADIUS);
  localparam logic [10:0]        C_XMAX  = 11'(SCREEN_W - 1 - RADIUS);
  localparam logic signed [10:0] C_YMIN  = 11'(RADIUS);
  localparam logic signed [10:0] C_YMAX  = 11'(SCREEN_H - 1 - RADIUS);
  localparam logic signed [10:0] C_GRAV  = 11'(GRAVITY);
  localparam logic signed [10:0] C_MAXVY = 11'(MAX_VY);

  logic [1:0] state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, nx_q, nx_d, ny_q, ny_d;
  logic [5:0] vy_q, vy_d, nvy_q, nvy_d;
  logic       dir_q, dir_d, ndir_q, ndir_d;
  logic       bx_q, bx_d, by_q, by_d;
  logic       bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
  logic       missed_q, missed_d, kick_pending_q, kick_pending_d;
  logic [7:0] frame_count_q, frame_count_d;

  logic [2:0]         vx;
  logic [10:0]        x_sum, x_left_lim;
  logic signed [10:0] vy_ext, vg, vt, yc, damp, nvy_full;

  assign vx         = {1'b0, speed_sel} + 3'd1;
  assign x_sum      = {1'b0, x_q} + {8'b0, vx};
  assign x_left_lim = C_XMIN + {8'b0, vx};

  assign vy_ext   = {{5{vy_q[5]}}, vy_q};
  assign vg       = vy_ext + C_GRAV;
  assign vt       = kick_pending_q ? -C_MAXVY : ((vg > C_MAXVY) ? C_MAXVY : vg);
  assign yc       = $signed({1'b0, y_q}) + vt;
  // Floor rebound keeps 3/4 of the impact speed.
  assign damp     = vt - (vt >>> 2);
  assign nvy_full = -damp;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    vy_d          = vy_q;
    dir_d         = dir_q;
    nx_d          = nx_q;
    ny_d          = ny_q;
    nvy_d         = nvy_q;
    ndir_d        = ndir_q;
    bx_d          = bx_q;
    by_d          = by_q;
    bounce_x_d    = 1'b0;
    bounce_y_d    = 1'b0;
    frame_count_d = frame_count_q;
    // A kick landing in the consuming cycle survives for the next frame.
    kick_pending_d = kick | (kick_pending_q & (state_q != ST_CALC_Y));
    missed_d       = missed_q | (frame_tick & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (frame_tick && !pause) state_d = ST_CALC_X;
      end
      ST_CALC_X: begin
        bx_d   = 1'b0;
        ndir_d = dir_q;
        if (dir_q) begin
          if (x_sum >= C_XMAX) begin
            nx_d   = C_XMAX[9:0];
            ndir_d = 1'b0;
            bx_d   = 1'b1;
          end else begin
            nx_d = x_sum[9:0];
          end
        end else begin
          if ({1'b0, x_q} <= x_left_lim) begin
            nx_d   = C_XMIN[9:0];
            ndir_d = 1'b1;
            bx_d   = 1'b1;
          end else begin
            nx_d = x_q - {7'b0, vx};
          end
        end
        state_d = ST_CALC_Y;
      end
      ST_CALC_Y: begin
        if (yc >= C_YMAX) begin
          ny_d  = C_YMAX[9:0];
          nvy_d = ((nvy_full > -11'sd2) && (nvy_full < 11'sd2)) ? 6'd0 : nvy_full[5:0];
          by_d  = 1'b1;
        end else if (yc <= C_YMIN) begin
          ny_d  = C_YMIN[9:0];
          nvy_d = 6'd0;
          by_d  = 1'b1;
        end else begin
          ny_d  = yc[9:0];
          nvy_d = vt[5:0];
          by_d  = 1'b0;
        end
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        x_d           = nx_q;
        y_d           = ny_q;
        vy_d          = nvy_q;
        dir_d         = ndir_q;
        bounce_x_d    = bx_q;
        bounce_y_d    = by_q;
        frame_count_d = frame_count_q + 8'd1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      x_q            <= 10'(INIT_X);
      y_q            <= 10'(INIT_Y);
      vy_q           <= 6'd0;
      dir_q          <= 1'b1;
      nx_q           <= 10'(INIT_X);
      ny_q           <= 10'(INIT_Y);
      nvy_q          <= 6'd0;
      ndir_q         <= 1'b1;
      bx_q           <= 1'b0;
      by_q           <= 1'b0;
      bounce_x_q     <= 1'b0;
      bounce_y_q     <= 1'b0;
      missed_q       <= 1'b0;
      kick_pending_q <= 1'b0;
      frame_count_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      vy_q           <= vy_d;
      dir_q          <= dir_d;
      nx_q           <= nx_d;
      ny_q           <= ny_d;
      nvy_q          <= nvy_d;
      ndir_q         <= ndir_d;
      bx_q           <= bx_d;
      by_q           <= by_d;
      bounce_x_q     <= bounce_x_d;
      bounce_y_q     <= bounce_y_d;
      missed_q       <= missed_d;
      kick_pending_q <= kick_pending_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign vy_out      = vy_q;
  assign busy        = (state_q != ST_IDLE);
  assign bounce_x    = bounce_x_q;
  assign bounce_y    = bounce_y_q;
  assign missed_tick = missed_q;
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_physics.sv
`default_nettype none
// ============================================================================
// Module  : tb_ball_physics
// Purpose : Directed table-driven bench for ball_physics
// Rev     : 1.0  initial release
// ============================================================================
module tb_ball_physics;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       pause;
  logic       kick;
  logic [1:0] speed_sel;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [5:0] vy_out;
  logic       busy;
  logic       bounce_x;
  logic       bounce_y;
  logic       missed_tick;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_pass   = 0;

  ball_physics dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .pause       (pause),
    .kick        (kick),
    .speed_sel   (speed_sel),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .vy_out      (vy_out),
    .busy        (busy),
    .bounce_x    (bounce_x),
    .bounce_y    (bounce_y),
    .missed_tick (missed_tick),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 reps;
    logic [1:0]         spd;
    logic               kk;
    logic [9:0]         ex;
    logic [9:0]         ey;
    logic signed [5:0]  evy;
    logic               ebx;
    logic               eby;
    logic [7:0]         efc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame; returns at E3+1, with bounce pulses visible.
  task automatic run_frame(input logic [1:0] spd, input logic kk,
                           output logic busy_mid, output logic busy_end);
    speed_sel = spd;
    if (kk) begin
      kick = 1'b1;
      step();
      kick = 1'b0;
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    busy_mid = busy;
    step();
    step();
    busy_end = busy;
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey, input int evy,
                           input int efc);
    check({tag, "_x"},  int'(ball_x), ex);
    check({tag, "_y"},  int'(ball_y), ey);
    check({tag, "_vy"}, int'($signed(vy_out)), evy);
    check({tag, "_fc"}, int'(frame_count), efc);
  endtask

  initial begin
    logic bm, be;
    rst_n = 1'b0; frame_tick = 1'b0; pause = 1'b0; kick = 1'b0; speed_sel = 2'd1;

    vecs[0] = '{1,  2'd1, 1'b0, 10'd322, 10'd241, 6'sd1,   1'b0, 1'b0, 8'd1};
    vecs[1] = '{1,  2'd1, 1'b0, 10'd324, 10'd243, 6'sd2,   1'b0, 1'b0, 8'd2};
    vecs[2] = '{20, 2'd3, 1'b0, 10'd404, 10'd459, -6'sd12, 1'b0, 1'b1, 8'd22};
    vecs[3] = '{1,  2'd3, 1'b0, 10'd408, 10'd448, -6'sd11, 1'b0, 1'b0, 8'd23};
    vecs[4] = '{52, 2'd3, 1'b0, 10'd616, 10'd454, -6'sd2,  1'b0, 1'b0, 8'd75};
    vecs[5] = '{1,  2'd3, 1'b0, 10'd619, 10'd453, -6'sd1,  1'b1, 1'b0, 8'd76};
    vecs[6] = '{1,  2'd3, 1'b0, 10'd615, 10'd453, 6'sd0,   1'b0, 1'b0, 8'd77};
    vecs[7] = '{13, 2'd0, 1'b0, 10'd602, 10'd459, 6'sd0,   1'b0, 1'b1, 8'd90};
    vecs[8] = '{1,  2'd0, 1'b1, 10'd601, 10'd444, -6'sd15, 1'b0, 1'b0, 8'd91};
    vecs[9] = '{1,  2'd0, 1'b0, 10'd600, 10'd430, -6'sd14, 1'b0, 1'b0, 8'd92};

    repeat (3) step();
    rst_n = 1'b1;
    check_pos("reset", 320, 240, 0, 0);
    check("reset_busy", int'(busy), 0);
    check("reset_bounce", int'({bounce_x, bounce_y}), 0);
    check("reset_missed", int'(missed_tick), 0);

    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        run_frame(vecs[i].spd, vecs[i].kk, bm, be);
        if (r == vecs[i].reps - 1) begin
          check_pos($sformatf("vec%0d", i), int'(vecs[i].ex), int'(vecs[i].ey),
                    int'(vecs[i].evy), int'(vecs[i].efc));
          check($sformatf("vec%0d_bx", i), int'(bounce_x), int'(vecs[i].ebx));
          check($sformatf("vec%0d_by", i), int'(bounce_y), int'(vecs[i].eby));
          check($sformatf("vec%0d_busy_mid", i), int'(bm), 1);
          check($sformatf("vec%0d_busy_end", i), int'(be), 0);
        end
        step();
        if (r == vecs[i].reps - 1)
          check($sformatf("vec%0d_pulse_clr", i), int'({bounce_x, bounce_y}), 0);
      end
    end

    // Two kicks before one tick launch only once.
    kick = 1'b1; step(); kick = 1'b0; step();
    kick = 1'b1; step(); kick = 1'b0;
    run_frame(2'd0, 1'b0, bm, be);
    check_pos("dblkick", 599, 415, -15, 93);
    step();
    run_frame(2'd0, 1'b0, bm, be);
    check_pos("dblkick_next", 598, 401, -14, 94);
    step();

    // Kick arriving in the consuming cycle stays pending for the next frame.
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); kick = 1'b1;
    step(); kick = 1'b0;
    step();
    check_pos("latekick", 597, 388, -13, 95);
    step();
    run_frame(2'd0, 1'b0, bm, be);
    check_pos("latekick_next", 596, 373, -15, 96);
    step();

    // Paused tick is ignored.
    pause = 1'b1; frame_tick = 1'b1; step(); frame_tick = 1'b0; pause = 1'b0;
    check("pause_busy", int'(busy), 0);
    repeat (3) step();
    check_pos("pause", 596, 373, -15, 96);
    check("pause_missed", int'(missed_tick), 0);

    // Tick during busy is dropped and sets the sticky flag.
    frame_tick = 1'b1; step();
    step(); frame_tick = 1'b0;
    step(); step();
    check_pos("missed", 595, 359, -14, 97);
    check("missed_flag", int'(missed_tick), 1);
    step();
    run_frame(2'd0, 1'b0, bm, be);
    check_pos("missed_next", 594, 346, -13, 98);
    check("missed_sticky", int'(missed_tick), 1);
    step();

    // Reset while in CALC_Y aborts the update.
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    check_pos("midrst", 320, 240, 0, 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_bounce", int'({bounce_x, bounce_y}), 0);
    check("midrst_missed", int'(missed_tick), 0);
    step();
    check_pos("midrst_idle", 320, 240, 0, 0);
    run_frame(2'd1, 1'b0, bm, be);
    check_pos("postrst", 322, 241, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
